nfu2_accumulator: RTL and testbench

//  Downstream stage of the NFU-1 multiply-add stage (nbin*sb+nbout).
//  - Consumes a stream of N-bit signed partial sums from NFU-1.
//  - Accumulates a programmable number of partial sums per output neuron, starting from a bias (nbout) value.
//  - Saturates the total and presents it to the NBout writeback with a valid/ready handshake.

---
 rtl/nfu2_accumulator_if.sv | 31 +++
 rtl/nfu2_accumulator.sv | 130 +++++++++++++
 tb/tb_nfu2_accumulator.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nfu2_accumulator_if.sv
// nfu2_accumulator_if
//   Bundles the group configuration, the partial-sum input stream and the
//   result output stream of the NFU-2 accumulator.
//   Ports (by modport):
//     slave  (the accumulator): in  i_cfg_len, i_bias, i_valid, i_psum, i_ready
//                               out o_ready, o_valid, o_res, o_busy
//     master (NFU-1 / NBout side): the mirror image of slave
interface nfu2_accumulator_if #(
    parameter int N     = 16,
    parameter int LEN_W = 8
);
    logic [LEN_W-1:0] i_cfg_len;
    logic [N-1:0]     i_bias;
    logic             i_valid;
    logic             o_ready;
    logic [N-1:0]     i_psum;
    logic             o_valid;
    logic             i_ready;
    logic [N-1:0]     o_res;
    logic             o_busy;

    modport slave (
        input  i_cfg_len, i_bias, i_valid, i_psum, i_ready,
        output o_ready, o_valid, o_res, o_busy
    );

    modport master (
        output i_cfg_len, i_bias, i_valid, i_psum, i_ready,
        input  o_ready, o_valid, o_res, o_busy
    );
endinterface

// File: rtl/nfu2_accumulator.sv
// nfu2_accumulator
//   Accumulates a programmable number of signed partial sums from NFU-1 on
//   top of a bias value, saturates the total to N bits and hands it to the
//   NBout writeback over a valid/ready handshake.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  nfu2_accumulator_if.slave: configuration (i_cfg_len, i_bias),
//          partial-sum stream (i_valid/o_ready/i_psum), result stream
//          (o_valid/i_ready/o_res) and o_busy status
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for the first beat of a group; samples len and bias
//   S_ACCUM | adding further beats until cnt reaches the sampled length
//   S_DONE  | result presented on o_res/o_valid until the consumer takes it
module nfu2_accumulator #(
    parameter int N     = 16,
    parameter int G     = 4,
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    nfu2_accumulator_if.slave   bus
);

    localparam int ACC_W = N + G;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [LEN_W-1:0]   cnt_q, cnt_d;
    logic        [LEN_W-1:0]   len_q, len_d;
    logic        [N-1:0]       res_q, res_d;

    logic                      beat;
    logic        [LEN_W-1:0]   len_eff;
    logic        [LEN_W-1:0]   cnt_inc;
    logic signed [ACC_W-1:0]   psum_ext;
    logic signed [ACC_W-1:0]   bias_ext;

    // Clamp the wide accumulator into N bits: the value fits when all bits
    // from the N-bit sign position upward agree.
    function automatic logic [N-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic [G:0] upper;
        upper = v[ACC_W-1:N-1];
        if ((&upper) || !(|upper)) begin
            return v[N-1:0];
        end else if (v[ACC_W-1]) begin
            return {1'b1, {(N-1){1'b0}}};
        end else begin
            return {1'b0, {(N-1){1'b1}}};
        end
    endfunction

    assign bus.o_ready = (state_q != S_DONE);
    assign bus.o_valid = (state_q == S_DONE);
    assign bus.o_busy  = (state_q != S_IDLE);
    assign bus.o_res   = res_q;

    assign beat     = bus.i_valid && bus.o_ready;
    assign len_eff  = (bus.i_cfg_len == '0) ? LEN_W'(1) : bus.i_cfg_len;
    assign cnt_inc  = cnt_q + LEN_W'(1);
    assign psum_ext = ACC_W'(signed'(bus.i_psum));
    assign bias_ext = ACC_W'(signed'(bus.i_bias));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        res_d   = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (beat) begin
                    acc_d   = bias_ext + psum_ext;
                    len_d   = len_eff;
                    cnt_d   = LEN_W'(1);
                    state_d = (len_eff == LEN_W'(1)) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + psum_ext;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (bus.i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result is captured only on entry to DONE so it stays stable while
        // the consumer stalls.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            res_d = saturate(acc_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_nfu2_accumulator.sv
// tb_nfu2_accumulator
//   Self-checking bench for nfu2_accumulator. Expected results come from a
//   plain-integer model: bias plus the sum of the group's partial sums,
//   clamped to the signed 16-bit range.
module tb_nfu2_accumulator;

    localparam int N     = 16;
    localparam int G     = 4;
    localparam int LEN_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    nfu2_accumulator_if #(.N(N), .LEN_W(LEN_W)) bus ();

    nfu2_accumulator #(.N(N), .G(G), .LEN_W(LEN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] bias, input int ps[$]);
        int s;
        s = int'($signed(bias));
        foreach (ps[i]) s += ps[i];
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    // Drives one full group (ps.size() beats) with random bubbles, checks the
    // result one cycle after the last beat, stalls the consumer for 'hold'
    // cycles and completes the handshake. Starts and ends on a negedge.
    task automatic run_group(input int len, input logic [15:0] bias, input int ps[$],
                             input int bubble_pct, input int hold);
        logic [15:0] exp;
        exp = model(bias, ps);
        bus.i_cfg_len = LEN_W'(len);
        bus.i_bias    = bias;
        for (int i = 0; i < ps.size(); i++) begin
            while (int'($urandom_range(99)) < bubble_pct) begin
                bus.i_valid = 1'b0;
                bus.i_psum  = 16'($urandom);
                @(negedge clk);
                check("bubble_valid", 32'(bus.o_valid), 32'(0));
            end
            check("ready_in", 32'(bus.o_ready), 32'(1));
            check("no_early_valid", 32'(bus.o_valid), 32'(0));
            bus.i_valid = 1'b1;
            bus.i_psum  = 16'(ps[i]);
            @(negedge clk);
            // later config changes must be ignored by the group in flight
            bus.i_cfg_len = LEN_W'($urandom);
            bus.i_bias    = 16'($urandom);
        end
        // keep offering junk beats in DONE; none may be taken
        bus.i_valid = 1'b1;
        bus.i_psum  = 16'($urandom);
        check("valid_after_last", 32'(bus.o_valid), 32'(1));
        check("res", 32'(bus.o_res), 32'(exp));
        check("ready_done", 32'(bus.o_ready), 32'(0));
        check("busy_done", 32'(bus.o_busy), 32'(1));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.o_valid), 32'(1));
            check("hold_res", 32'(bus.o_res), 32'(exp));
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b0;
        check("valid_after_hs", 32'(bus.o_valid), 32'(0));
        check("busy_after_hs", 32'(bus.o_busy), 32'(0));
        check("ready_after_hs", 32'(bus.o_ready), 32'(1));
    endtask

    initial begin
        int q[$];
        int len;
        int n;

        rst           = 1'b1;
        bus.i_cfg_len = '0;
        bus.i_bias    = '0;
        bus.i_valid   = 1'b0;
        bus.i_psum    = '0;
        bus.i_ready   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'(0));
        check("rst_res", 32'(bus.o_res), 32'(0));
        check("rst_busy", 32'(bus.o_busy), 32'(0));
        check("rst_ready", 32'(bus.o_ready), 32'(1));
        rst = 1'b0;
        @(negedge clk);

        // basic group: 10+1+2+3+4 = 20
        q = {1, 2, 3, 4};
        run_group(4, 16'd10, q, 0, 2);

        // single-beat groups, len 1 and len 0
        q = {3};
        run_group(1, 16'hFFFB, q, 0, 0);
        run_group(0, 16'hFFFB, q, 0, 1);

        // saturation in both directions
        q = {256, 256, 256};
        run_group(3, 16'h7F00, q, 0, 0);
        q = {-1, -1, -1};
        run_group(3, 16'h8000, q, 0, 0);

        // bubbles and a long consumer stall
        q = {100, -50, 7};
        run_group(3, 16'd1234, q, 50, 5);

        // reset aborts a group after its 2nd beat
        bus.i_cfg_len = LEN_W'(4);
        bus.i_bias    = 16'd0;
        bus.i_valid   = 1'b1;
        bus.i_psum    = 16'd1;
        @(negedge clk);
        bus.i_psum    = 16'd2;
        @(negedge clk);
        bus.i_valid   = 1'b0;
        rst           = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        check("abort_busy", 32'(bus.o_busy), 32'(0));
        check("abort_ready", 32'(bus.o_ready), 32'(1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_valid", 32'(bus.o_valid), 32'(0));
        end
        q = {7, 8};
        run_group(2, 16'd0, q, 0, 0);

        // reset wins over a simultaneous handshake in DONE
        bus.i_cfg_len = LEN_W'(1);
        bus.i_bias    = 16'd40;
        bus.i_valid   = 1'b1;
        bus.i_psum    = 16'd2;
        @(negedge clk);
        bus.i_valid   = 1'b0;
        check("pre_rst_res", 32'(bus.o_res), 32'(42));
        rst           = 1'b1;
        bus.i_ready   = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.i_ready   = 1'b0;
        check("rst_prio_res", 32'(bus.o_res), 32'(0));
        check("rst_prio_valid", 32'(bus.o_valid), 32'(0));

        // back-to-back groups, no bubbles
        q = {5, 6};
        run_group(2, 16'd100, q, 0, 0);
        q = {-20, 9};
        run_group(2, 16'hFFF0, q, 0, 0);

        // randomized groups
        for (int g = 0; g < 40; g++) begin
            len = int'($urandom_range(15));
            n   = (len == 0) ? 1 : len;
            q   = {};
            for (int b = 0; b < n; b++) begin
                q.push_back(int'($signed(16'($urandom))));
            end
            run_group(len, 16'($urandom), q, 30, int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
